// File: rtl/counter_pkg.sv
// counter_pkg: shared digit width and count direction for the BCD counter
package counter_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic {DIR_DOWN, DIR_UP} dir_e;
endpackage

// File: rtl/radix_digit.sv
// radix_digit: one modulo-RADIX digit with load, clear and ripple step in/out
module radix_digit
  import counter_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               step_in,
  input  logic               up,
  output logic [DIGIT_W-1:0] value,
  output logic               step_out
);
  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(RADIX - 1);
  logic               at_edge;
  logic               go_up;
  logic [DIGIT_W-1:0] nxt;
  // next digit value: clear beats load beats step; out-of-range loads become 0
  always_comb begin
    go_up    = dir_e'(up) == DIR_UP;
    at_edge  = go_up ? value == TOP : value == '0;
    step_out = step_in & at_edge;
    nxt      = clear ? '0 :
               load ? (({1'b0, load_val} >= (DIGIT_W + 1)'(RADIX)) ? '0 : load_val) :
               !step_in ? value :
               go_up ? (at_edge ? '0 : value + 1'b1) :
               (at_edge ? TOP : value - 1'b1);
  end
  // digit register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) value <= '0;
    else value <= nxt;
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: cascaded up/down radix counter with wrap or saturate and event flags
module bcd_updown_counter
  import counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 10,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_data,
  input  logic                      en,
  input  logic                      up,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      carry,
  output logic                      borrow,
  output logic                      load_err
);
  localparam logic [DIGIT_W*DIGITS-1:0] MAX = {DIGITS{DIGIT_W'(RADIX - 1)}};
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] bad;
  logic              cmd;
  logic              lim;
  logic              step0;
  logic              carry_d;
  logic              borrow_d;
  logic              err_d;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      radix_digit #(.RADIX(RADIX)) u_dig (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .load    (load),
        .load_val(load_data[DIGIT_W*i +: DIGIT_W]),
        .step_in (chain[i]),
        .up      (up),
        .value   (count[DIGIT_W*i +: DIGIT_W]),
        .step_out(chain[i+1])
      );
      assign bad[i] = {1'b0, load_data[DIGIT_W*i +: DIGIT_W]} >= (DIGIT_W + 1)'(RADIX);
    end
  endgenerate
  assign chain[0] = step0;
  // a step at the limit either wraps through the ripple chain or is suppressed when saturating
  always_comb begin
    cmd      = en & ~clear & ~load;
    lim      = up ? count == MAX : count == '0;
    step0    = cmd & ~((SATURATE != 0) & lim);
    carry_d  = up & ((SATURATE != 0) ? cmd & lim : chain[DIGITS]);
    borrow_d = ~up & ((SATURATE != 0) ? cmd & lim : chain[DIGITS]);
    err_d    = load & ~clear & (|bad);
  end
  // one-cycle registered event flags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {carry, borrow, load_err} <= '0;
    else {carry, borrow, load_err} <= {carry_d, borrow_d, err_d};
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed checks of wrap, saturate and hex variants
module tb_bcd_updown_counter;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        clear = 0;
  logic        load = 0;
  logic [15:0] load_data = '0;
  logic        en = 0;
  logic        up = 0;
  logic [15:0] cnt0, cnt1;
  logic [7:0]  cnt2;
  logic        cy0, bw0, le0, cy1, bw1, le1, cy2, bw2, le2;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        seen;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .RADIX(10), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_data(load_data),
    .en(en), .up(up), .count(cnt0), .carry(cy0), .borrow(bw0), .load_err(le0));
  bcd_updown_counter #(.DIGITS(4), .RADIX(10), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_data(load_data),
    .en(en), .up(up), .count(cnt1), .carry(cy1), .borrow(bw1), .load_err(le1));
  bcd_updown_counter #(.DIGITS(2), .RADIX(16), .SATURATE(0)) u_hex (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_data(load_data[7:0]),
    .en(en), .up(up), .count(cnt2), .carry(cy2), .borrow(bw2), .load_err(le2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_count", cnt0, 32'h0);
    check("rst_flags", {cy0, bw0, le0}, 32'h0);
    reset_n = 1;
    en = 1;
    up = 1;
    seen = 0;
    repeat (12) begin
      tick();
      seen |= cy0;
    end
    check("up12_count", cnt0, 32'h0012);
    check("up12_nocarry", seen, 32'h0);
    check("up12_hex", cnt2, 32'h0c);
    en = 0;
    load = 1;
    load_data = 16'h9998;
    tick();
    check("ld9998", cnt0, 32'h9998);
    check("ld9998_err", le0, 32'h0);
    load = 0;
    en = 1;
    tick();
    check("to9999", cnt0, 32'h9999);
    check("to9999_cy", cy0, 32'h0);
    tick();
    check("wrap_count", cnt0, 32'h0000);
    check("wrap_carry", cy0, 32'h1);
    check("sat_hold_max", cnt1, 32'h9999);
    check("sat_carry", cy1, 32'h1);
    en = 0;
    tick();
    check("carry_drop", cy0, 32'h0);
    check("hold_count", cnt0, 32'h0000);
    clear = 1;
    en = 1;
    up = 0;
    tick();
    check("clr_sat", cnt1, 32'h0000);
    check("clr_noborrow", {bw0, bw1}, 32'h0);
    clear = 0;
    tick();
    check("dn_wrap", cnt0, 32'h9999);
    check("dn_borrow", bw0, 32'h1);
    check("sat_hold_zero", cnt1, 32'h0000);
    check("sat_borrow", bw1, 32'h1);
    en = 0;
    tick();
    check("borrow_drop", {bw0, bw1}, 32'h0);
    load = 1;
    load_data = 16'h12A4;
    tick();
    check("ld_bad", cnt0, 32'h1204);
    check("ld_bad_err", le0, 32'h1);
    check("ld_hex_ok", {cnt2, 7'h0, le2}, 32'ha400);
    load = 0;
    tick();
    check("err_drop", le0, 32'h0);
    load = 1;
    clear = 1;
    en = 1;
    up = 1;
    tick();
    check("clr_ld_count", cnt0, 32'h0000);
    check("clr_ld_flags", {cy0, bw0, le0}, 32'h0);
    load = 0;
    clear = 0;
    tick();
    tick();
    check("pre_rst", cnt0, 32'h0002);
    #2;
    reset_n = 0;
    #1;
    check("async_rst", cnt0, 32'h0000);
    tick();
    reset_n = 1;
    tick();
    check("post_rst", cnt0, 32'h0001);
    en = 0;
    load = 1;
    load_data = 16'h00FF;
    tick();
    check("hex_ldff", cnt2, 32'hff);
    check("hex_ld_noerr", le2, 32'h0);
    load = 0;
    en = 1;
    up = 1;
    tick();
    check("hex_wrap", cnt2, 32'h00);
    check("hex_carry", cy2, 32'h1);
    for (int k = 0; k < 4; k++) begin
      up = (k % 2 == 0);
      tick();
      check("hex_toggle", cnt2, up ? 32'h01 : 32'h00);
      check("hex_noborrow", bw2, 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of cascaded digits (1..8).
REQ-002 Parameter RADIX, default 10, SHALL set the per-digit modulus (2..16); every digit counts 0..RADIX-1.
REQ-003 Parameter SATURATE, default 0, SHALL select wrap-around (0) or clamp-at-limit (1) behaviour.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous clear of all digits to 0.
REQ-007 load  input  1  synchronous parallel load from load_data.
REQ-008 load_data  input  4*DIGITS  load value, digit i in bits [4i+3:4i], digit 0 least significant.
REQ-009 en  input  1  count enable; one step per enabled cycle.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 count  output  4*DIGITS  registered counter value, same packing as load_data.
REQ-012 carry  output  1  registered one-cycle pulse on up-wrap or up-clamp attempt at maximum.
REQ-013 borrow  output  1  registered one-cycle pulse on down-wrap or down-clamp attempt at zero.
REQ-014 load_err  output  1  registered one-cycle pulse when a load contained an out-of-range digit.

Function
REQ-015 Command priority SHALL be clear > load > en; with none asserted, count SHALL hold.
REQ-016 Increment SHALL step digit 0; a digit at RADIX-1 SHALL become 0 and propagate a ripple carry to the next digit in the same cycle.
REQ-017 Decrement SHALL step digit 0; a digit at 0 SHALL become RADIX-1 and propagate a ripple borrow to the next digit in the same cycle.
REQ-018 Count latency SHALL be one cycle: the value appears on count at the edge that samples en=1.
REQ-019 Maximum is all digits RADIX-1; SATURATE=0 increment from maximum SHALL give all zeros and pulse carry on the same edge.
REQ-020 SATURATE=0 decrement from all zeros SHALL give maximum and pulse borrow on the same edge.
REQ-021 SATURATE=1 increment at maximum SHALL hold count and pulse carry; decrement at zero SHALL hold count and pulse borrow.
REQ-022 carry and borrow SHALL be low in every cycle not described in REQ-019..021, including clear and load cycles.
REQ-023 A loaded digit >= RADIX SHALL be stored as 0; other digits load unchanged; load_err SHALL pulse for one cycle on that edge.
REQ-024 en and up SHALL be ignored in clear or load cycles.
REQ-025 Direction changes between consecutive enabled cycles SHALL take effect immediately, with no extra latency.
REQ-026 count SHALL never hold a digit >= RADIX.

Reset
REQ-027 reset_n low SHALL force count to 0 and carry, borrow and load_err to 0 immediately, without waiting for clk.
REQ-028 Reset asserted mid-count SHALL discard any in-flight step; the first step after release SHALL start from 0.
REQ-029 The first rising edge after reset_n deasserts SHALL be a normal functional cycle.

Structure
REQ-030 Package counter_pkg SHALL hold DIGIT_W = 4 and the direction enum {DIR_DOWN, DIR_UP}.
REQ-031 Sub-module radix_digit SHALL implement one digit with ports clk, reset_n, clear, load, load_val, step_in, up, value, step_out.
REQ-032 bcd_updown_counter SHALL instantiate DIGITS radix_digit instances in a generate chain, plus the registered carry, borrow and load_err flags.
REQ-033 The ripple step chain SHALL be combinational within one cycle; no per-digit pipelining.

Verification (DIGITS=4, RADIX=10 unless stated)
REQ-034 reset_n low, then en=1 and up=1 for 12 cycles -> count 0x0012; carry never asserted.
REQ-035 load 0x9998, then 2 up steps -> 0x9999, then 0x0000 with carry high for exactly that one cycle.
REQ-036 From 0x0000, one down step -> 0x9999 with borrow pulse; with SATURATE=1 -> count holds 0x0000 and borrow pulses.
REQ-037 load 0x12A4 -> count 0x1204 and load_err pulses; load and clear together -> count 0x0000 and load_err stays low.
REQ-038 While counting, drop reset_n between edges -> count goes to 0 asynchronously; after release, the first up step gives 0x0001.
REQ-039 RADIX=16, DIGITS=2: load 0xFF, one up step -> 0x00 with carry; alternate up and down each cycle -> count toggles 0x00/0x01 with no borrow.
